// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared codes, state encoding and address map for the AHB-APB bridge
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HRESP_OKAY  = 3'b000;
    localparam logic [2:0] HRESP_ERROR = 3'b001;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_P0   = 3'b001;
    localparam logic [2:0] SEL_P1   = 3'b010;
    localparam logic [2:0] SEL_P2   = 3'b100;

    localparam logic [31:0] P0_BASE  = 32'h8000_0000;
    localparam logic [31:0] P0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] P1_BASE  = 32'h8400_0000;
    localparam logic [31:0] P1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] P2_BASE  = 32'h8800_0000;
    localparam logic [31:0] P2_LIMIT = 32'h8BFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DPHASE,
        ST_REQ,
        ST_RESP,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahb_addr_decode.sv
// rtl/ahb_addr_decode.sv - combinational AHB address to one-hot peripheral select
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              in_range,
    output logic [2:0]        sel
);

    always_comb begin
        sel = SEL_NONE;
        if (addr >= ADDR_W'(P0_BASE) && addr <= ADDR_W'(P0_LIMIT)) begin
            sel = SEL_P0;
        end else if (addr >= ADDR_W'(P1_BASE) && addr <= ADDR_W'(P1_LIMIT)) begin
            sel = SEL_P1;
        end else if (addr >= ADDR_W'(P2_BASE) && addr <= ADDR_W'(P2_LIMIT)) begin
            sel = SEL_P2;
        end
    end

    assign in_range = (sel != SEL_NONE);

endmodule

// File: rtl/ahb_slave_interface.sv
// rtl/ahb_slave_interface.sv - AHB slave front-end issuing one APB request per transfer
module ahb_slave_interface
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    output logic              Hreadyout,
    output logic [2:0]        Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [2:0]        req_sel,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata
);

    state_t      state;
    logic        xfer_valid;
    logic        dec_in_range;
    logic [2:0]  dec_sel;

    ahb_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
        .addr     (Haddr),
        .in_range (dec_in_range),
        .sel      (dec_sel)
    );

    assign xfer_valid = Hreadyin && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ);

    // Outputs are updated alongside the state so they behave as Moore outputs of the next state.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state     <= ST_IDLE;
            Hreadyout <= 1'b1;
            Hresp     <= HRESP_OKAY;
            Hrdata    <= '0;
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_sel   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    if (xfer_valid && dec_in_range) begin
                        state     <= ST_DPHASE;
                        Hreadyout <= 1'b0;
                        Hresp     <= HRESP_OKAY;
                        req_addr  <= Haddr;
                        req_write <= Hwrite;
                        req_sel   <= dec_sel;
                    end else if (xfer_valid) begin
                        state     <= ST_ERR1;
                        Hreadyout <= 1'b0;
                        Hresp     <= HRESP_ERROR;
                    end else begin
                        state     <= ST_IDLE;
                        Hreadyout <= 1'b1;
                        Hresp     <= HRESP_OKAY;
                    end
                end
                ST_DPHASE: begin
                    if (req_write) begin
                        req_wdata <= Hwdata;
                    end
                    state     <= ST_REQ;
                    req_valid <= 1'b1;
                end
                ST_REQ: begin
                    if (req_ready) begin
                        state     <= ST_RESP;
                        req_valid <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (rsp_valid) begin
                        // Writes leave Hrdata at the last read value.
                        if (!req_write) begin
                            Hrdata <= rsp_rdata;
                        end
                        state     <= ST_DONE;
                        Hreadyout <= 1'b1;
                        Hresp     <= HRESP_OKAY;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    Hreadyout <= 1'b1;
                    Hresp     <= HRESP_ERROR;
                end
                default: begin
                    state     <= ST_IDLE;
                    Hreadyout <= 1'b1;
                    Hresp     <= HRESP_OKAY;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ahb_slave_interface.md
# ahb_slave_interface

AHB slave front-end of the AHB-APB bridge, directly downstream of the AHB master. Accepts AHB address/data phases, decodes the target peripheral, holds write data, and issues one request per transfer to the APB controller over a valid/ready handshake. Stalls the master with `Hreadyout` until the APB side responds, then returns read data or a two-cycle ERROR response.

## Interface
Parameters:
- `ADDR_W`, 32, AHB/request address width
- `DATA_W`, 32, AHB/request data width

Ports:
- `Hclk`  in  1  clock; all logic on rising edge
- `Hresetn`  in  1  reset, synchronous, active-low
- `Hwrite`  in  1  1 = write, 0 = read (address phase)
- `Hreadyin`  in  1  bus ready from master/mux
- `Htrans`  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- `Haddr`  in  ADDR_W  transfer address
- `Hwdata`  in  DATA_W  write data (data phase)
- `Hreadyout`  out  1  0 = stall master
- `Hresp`  out  3  000 OKAY, 001 ERROR
- `Hrdata`  out  DATA_W  read data
- `req_valid`  out  1  request to APB controller
- `req_ready`  in  1  APB controller accepts request
- `req_write`, `req_addr` (ADDR_W), `req_wdata` (DATA_W), `req_sel` (3)  out  request fields, one-hot select
- `rsp_valid`  in  1  APB transfer complete
- `rsp_rdata`  in  DATA_W  read data from APB

## Operation
- Valid transfer: `Hreadyin`=1 and `Htrans` ∈ {10,11}, sampled only in states where `Hreadyout`=1 (IDLE, DONE, ERR2). IDLE/BUSY: ignored, OKAY, no wait.
- Decode: 0x8000_0000–0x83FF_FFFF → sel 001; 0x8400_0000–0x87FF_FFFF → 010; 0x8800_0000–0x8BFF_FFFF → 100; else out of range.
- On valid in-range transfer: capture `Haddr`, `Hwrite`, sel; go DPHASE. Out of range: go ERR1, no request.
- States (registered, Moore outputs):
  - IDLE: `Hreadyout`=1, OKAY.
  - DPHASE: `Hreadyout`=0; at end of cycle capture `Hwdata` if write; → REQ.
  - REQ: `req_valid`=1, fields stable; → RESP when `req_ready`=1, else stay.
  - RESP: `Hreadyout`=0; on `rsp_valid` capture `rsp_rdata` (reads) → DONE.
  - DONE: `Hreadyout`=1, OKAY, `Hrdata` = captured data; new valid transfer → DPHASE/ERR1, else IDLE.
  - ERR1: `Hreadyout`=0, `Hresp`=001; → ERR2.
  - ERR2: `Hreadyout`=1, `Hresp`=001; accepts new transfer as DONE.
- `Hreadyout`=0 in DPHASE, REQ, RESP, ERR1. Master must hold address/data stable while stalled.
- Write `Hrdata` holds last read value.

## Timing
- Reset values: state IDLE, `Hreadyout`=1, `Hresp`=000, `Hrdata`=0, `req_valid`=0, all `req_*`=0.
- Address phase cycle N, zero backpressure: DPHASE N+1, `req_valid` N+2, RESP N+3, `rsp_valid` at N+3 → DONE N+4 (`Hreadyout`=1). Minimum 5 cycles per transfer.
- `rsp_valid` outside RESP is ignored; `req_ready` outside REQ is ignored.
- Back-to-back bursts: SEQ accepted in DONE, no idle cycle inserted.
- Reset mid-operation: next edge returns to IDLE, drops `req_valid` even if unaccepted; in-flight transfer is lost, APB side is reset together.

## Structure
- Package `ahb_apb_pkg`: HTRANS and HRESP codes, state enum, address-map base/limit constants, select encodings.
- Sub-module `ahb_addr_decode`: combinational `Haddr` → {in_range, sel[2:0]}. FSM and capture registers in top.

## Test plan
- Single write 0x80 to 0x8000_0001, `req_ready`=1, `rsp_valid` in first RESP cycle → `req_valid` at N+2 with addr 0x8000_0001, wdata 0x80, sel 001, write 1; `Hreadyout` 0 N+1..N+3, 1 at N+4.
- Single read 0x8800_0010, `rsp_rdata`=0xDEAD_BEEF → sel 100, write 0; `Hrdata`=0xDEAD_BEEF, OKAY in DONE.
- Address 0x9000_0000 NONSEQ → ERR1 (`Hreadyout` 0, `Hresp` 001), ERR2 (1, 001), `req_valid` never asserted.
- `req_ready` low 3 cycles in REQ → `req_valid` and fields held stable 4 cycles, then RESP.
- INCR4 write from 0x8400_0000, SEQ held while stalled → four requests, addresses 0x8400_0000..03, sel 010, wdata matching each beat; IDLE/BUSY or `Hreadyin`=0 cycles generate no request.
- `Hresetn`=0 during REQ → next cycle IDLE, `req_valid`=0, `Hreadyout`=1.
